// File: rtl/rvx_uart_fifo.sv
// rvx_uart_fifo: memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor and sticky error flags
module rvx_uart_fifo #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic        write_request,
  output logic        write_response,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLOCK_FREQUENCY / UART_BAUD_RATE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef logic [AW:0] ptr_t;
  logic [7:0] r_tx_mem [FIFO_DEPTH];
  logic [7:0] r_rx_mem [FIFO_DEPTH];
  ptr_t r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [15:0] r_baud_div;
  logic [1:0] r_ctrl;
  logic r_rx_ovr, r_frame_err, r_tx_ovf, r_irq, r_read_resp, r_write_resp, r_uart_tx;
  logic [31:0] r_read_data;
  state_t r_tx_state, w_tx_state_n, r_rx_state, w_rx_state_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n, r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n;
  logic [2:0] r_tx_bit, w_tx_bit_n, r_rx_bit, w_rx_bit_n, r_rx_sync;
  logic [7:0] r_tx_shift, w_tx_shift_n, r_rx_shift, w_rx_shift_n;
  ptr_t w_tx_count, w_rx_count;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [7:0] w_tx_head, w_rx_head;
  logic w_wr_tx, w_wr_stat, w_wr_baud, w_wr_ctrl;
  logic w_tx_push, w_tx_pop, w_tx_ovf_set, w_tx_load, w_tx_bit_end, w_tx_line;
  logic w_rx_push, w_rx_pop, w_rx_ovr_set, w_rx_done, w_rx_ferr, w_rx_bit_end, w_rx_s, w_rx_fall;
  logic [31:0] w_status, w_rd_data;
  logic w_unused;
  assign w_unused = ^write_data[31:16];
  // count MSB set means exactly FIFO_DEPTH entries: the wrap bits differ while indices match
  assign w_tx_count = r_tx_wr - r_tx_rd;
  assign w_rx_count = r_rx_wr - r_rx_rd;
  assign w_tx_empty = w_tx_count == '0;
  assign w_rx_empty = w_rx_count == '0;
  assign w_tx_full = w_tx_count[AW];
  assign w_rx_full = w_rx_count[AW];
  assign w_tx_head = r_tx_mem[r_tx_rd[AW-1:0]];
  assign w_rx_head = r_rx_mem[r_rx_rd[AW-1:0]];
  assign w_wr_tx = write_request && rw_address == 5'h00;
  assign w_wr_stat = write_request && rw_address == 5'h08;
  assign w_wr_baud = write_request && rw_address == 5'h10;
  assign w_wr_ctrl = write_request && rw_address == 5'h14;
  assign w_rx_pop = read_request && rw_address == 5'h04 && !w_rx_empty;
  assign w_tx_push = w_wr_tx && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf_set = w_wr_tx && w_tx_full && !w_tx_pop;
  assign w_rx_push = w_rx_done && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr_set = w_rx_done && w_rx_full && !w_rx_pop;
  assign w_tx_bit_end = r_tx_cnt == r_tx_div - 16'd1;
  assign w_tx_load = !w_tx_empty && (r_tx_state == IDLE || (r_tx_state == STOP && w_tx_bit_end));
  assign w_tx_pop = w_tx_load;
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n = r_tx_cnt + 16'd1;
    w_tx_bit_n = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_div_n = r_tx_div;
    case (r_tx_state)
      IDLE: w_tx_cnt_n = '0;
      START: if (w_tx_bit_end) begin
        w_tx_state_n = DATA;
        w_tx_cnt_n = '0;
        w_tx_bit_n = '0;
      end
      DATA: if (w_tx_bit_end) begin
        w_tx_state_n = r_tx_bit == 3'd7 ? STOP : DATA;
        w_tx_cnt_n = '0;
        w_tx_bit_n = r_tx_bit + 3'd1;
        w_tx_shift_n = r_tx_shift >> 1;
      end
      STOP: if (w_tx_bit_end) begin
        w_tx_state_n = IDLE;
        w_tx_cnt_n = '0;
      end
    endcase
    // back-to-back frames reload straight from STOP without passing through IDLE
    if (w_tx_load) begin
      w_tx_state_n = START;
      w_tx_cnt_n = '0;
      w_tx_shift_n = w_tx_head;
      w_tx_div_n = r_baud_div;
    end
    w_tx_line = w_tx_state_n == START ? 1'b0 : w_tx_state_n == DATA ? w_tx_shift_n[0] : 1'b1;
  end
  assign w_rx_s = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
  assign w_rx_bit_end = r_rx_cnt == r_rx_div - 16'd1;
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n = r_rx_cnt + 16'd1;
    w_rx_bit_n = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_div_n = r_rx_div;
    w_rx_done = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_n = '0;
        if (w_rx_fall) begin
          w_rx_state_n = START;
          w_rx_div_n = r_baud_div;
        end
      end
      START: if (r_rx_cnt == (r_rx_div >> 1) - 16'd1) begin
        w_rx_state_n = w_rx_s ? IDLE : DATA;
        w_rx_cnt_n = '0;
        w_rx_bit_n = '0;
      end
      DATA: if (w_rx_bit_end) begin
        w_rx_state_n = r_rx_bit == 3'd7 ? STOP : DATA;
        w_rx_cnt_n = '0;
        w_rx_bit_n = r_rx_bit + 3'd1;
        w_rx_shift_n = {w_rx_s, r_rx_shift[7:1]};
      end
      STOP: if (w_rx_bit_end) begin
        // a low stop bit cannot retrigger: IDLE needs a fresh falling edge
        w_rx_state_n = IDLE;
        w_rx_done = w_rx_s;
        w_rx_ferr = !w_rx_s;
      end
    endcase
  end
  assign w_status = {26'd0, r_tx_ovf, r_frame_err, r_rx_ovr, w_tx_empty && r_tx_state == IDLE, !w_rx_empty, !w_tx_full};
  assign w_rd_data = rw_address == 5'h04 ? {24'd0, w_rx_empty ? 8'd0 : w_rx_head} :
                     rw_address == 5'h08 ? w_status :
                     rw_address == 5'h0C ? {16'd0, 8'(w_tx_count), 8'(w_rx_count)} :
                     rw_address == 5'h10 ? {16'd0, r_baud_div} :
                     rw_address == 5'h14 ? {30'd0, r_ctrl} : 32'd0;
  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= write_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_rx_shift;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
      r_baud_div <= DIV_RST;
      r_ctrl <= '0;
      r_tx_ovf <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_irq <= 1'b0;
      r_read_resp <= 1'b0;
      r_write_resp <= 1'b0;
      r_read_data <= '0;
      r_tx_state <= IDLE;
      r_tx_cnt <= '0;
      r_tx_div <= DIV_RST;
      r_tx_bit <= '0;
      r_tx_shift <= '0;
      r_uart_tx <= 1'b1;
      r_rx_sync <= 3'b111;
      r_rx_state <= IDLE;
      r_rx_cnt <= '0;
      r_rx_div <= DIV_RST;
      r_rx_bit <= '0;
      r_rx_shift <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + ptr_t'(1);
      if (w_tx_pop) r_tx_rd <= r_tx_rd + ptr_t'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + ptr_t'(1);
      if (w_rx_pop) r_rx_rd <= r_rx_rd + ptr_t'(1);
      if (w_wr_baud) r_baud_div <= write_data[15:0] < 16'd4 ? 16'd4 : write_data[15:0];
      if (w_wr_ctrl) r_ctrl <= write_data[1:0];
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_wr_stat & write_data[5]));
      r_frame_err <= w_rx_ferr | (r_frame_err & ~(w_wr_stat & write_data[4]));
      r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~(w_wr_stat & write_data[3]));
      r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & (r_rx_ovr | r_frame_err | r_tx_ovf));
      r_read_resp <= read_request;
      r_write_resp <= write_request;
      r_read_data <= read_request ? w_rd_data : '0;
      r_tx_state <= w_tx_state_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_div <= w_tx_div_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_uart_tx <= w_tx_line;
      r_rx_sync <= {r_rx_sync[1:0], uart_rx};
      r_rx_state <= w_rx_state_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_div <= w_rx_div_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
    end
  end
  assign read_data = r_read_data;
  assign read_response = r_read_resp;
  assign write_response = r_write_resp;
  assign uart_tx = r_uart_tx;
  assign uart_irq = r_irq;
endmodule

// File: tb/tb_rvx_uart_fifo.sv
// tb_rvx_uart_fifo: directed and randomized checks of rvx_uart_fifo against an ideal serial/FIFO model
module tb_rvx_uart_fifo;
  localparam int DIV = 10;
  localparam int DEPTH = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rw_address = '0;
  logic [31:0] write_data = '0;
  logic read_request = 1'b0;
  logic write_request = 1'b0;
  logic uart_rx = 1'b1;
  logic [31:0] read_data;
  logic read_response, write_response, uart_tx, uart_irq;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [7:0] mon_q[$];
  int mon_t[$];
  bit mon_ok[$];
  logic [7:0] txm[$];
  rvx_uart_fifo #(.CLOCK_FREQUENCY(1000), .UART_BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response), .write_data(write_data),
    .write_request(write_request), .write_response(write_response),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_irq(uart_irq)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rw_address = a;
    write_data = d;
    write_request = 1'b1;
    tick(1);
    write_request = 1'b0;
    chk("wr_resp", 32'(write_response), 32'd1);
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    rw_address = a;
    read_request = 1'b1;
    tick(1);
    read_request = 1'b0;
    chk("rd_resp", 32'(read_response), 32'd1);
    d = read_data;
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(DIV);
    end
    uart_rx = 1'b1;
  endtask
  task automatic check_tx(input string tag, input bit contiguous);
    chk({tag, "_frames"}, 32'(mon_q.size()), 32'(txm.size()));
    for (int k = 0; k < txm.size(); k++) begin
      chk({tag, "_byte"}, k < mon_q.size() ? {24'd0, mon_q[k]} : 32'hxxxxxxxx, {24'd0, txm[k]});
      chk({tag, "_shape"}, k < mon_q.size() ? 32'(mon_ok[k]) : 32'hxxxxxxxx, 32'd1);
      if (contiguous && k > 0 && k < mon_q.size()) chk({tag, "_gap"}, 32'(mon_t[k] - mon_t[k-1]), 32'(10 * DIV));
    end
    mon_q.delete();
    mon_t.delete();
    mon_ok.delete();
    txm.delete();
  endtask
  // ideal receiver: captures a whole 10-bit frame and checks every cycle against the decoded byte
  initial begin
    logic [10*DIV-1:0] smp;
    logic [7:0] b;
    bit ok;
    int t0;
    forever begin
      @(negedge clock);
      if (mon_en && uart_tx === 1'b0) begin
        t0 = cyc;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge clock);
          smp[i] = uart_tx;
        end
        for (int k = 0; k < 8; k++) b[k] = smp[DIV*(k+1) + DIV/2];
        ok = 1'b1;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i < DIV) begin
            if (smp[i] !== 1'b0) ok = 1'b0;
          end else if (i >= 9 * DIV) begin
            if (smp[i] !== 1'b1) ok = 1'b0;
          end else if (smp[i] !== b[i/DIV - 1]) ok = 1'b0;
        end
        mon_q.push_back(b);
        mon_t.push_back(t0);
        mon_ok.push_back(ok);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    logic [7:0] b;
    logic [7:0] rxm[$];
    bit m_ovr;
    int lvl;
    tick(3);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_irq", 32'(uart_irq), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_rresp", 32'(read_response), 32'd0);
    chk("rst_wresp", 32'(write_response), 32'd0);
    reset = 1'b0;
    tick(1);
    rd(5'h08, d); chk("rst_status", d, 32'h05);
    rd(5'h10, d); chk("rst_baud", d, 32'd10);
    rd(5'h0C, d); chk("rst_count", d, 32'd0);
    rd(5'h18, d); chk("unmapped_rd", d, 32'd0);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h14, d); chk("ctrl_untouched", d, 32'd0);
    mon_en = 1'b1;
    wr(5'h00, 32'hA5); txm.push_back(8'hA5);
    tick(20);
    rd(5'h08, d); chk("busy_txidle", 32'(d[2]), 32'd0);
    tick(100);
    rd(5'h08, d); chk("done_txidle", 32'(d[2]), 32'd1);
    check_tx("a5", 1'b0);
    wr(5'h00, 32'h11); wr(5'h00, 32'h22); wr(5'h00, 32'h33);
    txm.push_back(8'h11); txm.push_back(8'h22); txm.push_back(8'h33);
    rd(5'h0C, d); chk("tx_count3", 32'(d[15:8]), 32'd2);
    tick(320);
    check_tx("b2b", 1'b1);
    b = 8'($urandom);
    wr(5'h00, {24'd0, b}); txm.push_back(b);
    tick(2);
    lvl = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      wr(5'h00, {24'd0, b});
      if (lvl < DEPTH) begin
        txm.push_back(b);
        lvl++;
      end
    end
    rd(5'h08, d); chk("tx_ovf_set", 32'(d[5]), 32'd1);
    rd(5'h0C, d); chk("tx_count_full", 32'(d[15:8]), 32'(lvl));
    wr(5'h08, 32'h20);
    rd(5'h08, d); chk("tx_ovf_clr", 32'(d[5]), 32'd0);
    tick(900);
    check_tx("ovf", 1'b1);
    wr(5'h14, 32'd1);
    rx_frame(8'h3C, 1'b1);
    tick(1);
    chk("rx_irq_set", 32'(uart_irq), 32'd1);
    rd(5'h04, d); chk("rx_3c", d, 32'h3C);
    tick(1);
    chk("rx_irq_clr", 32'(uart_irq), 32'd0);
    rd(5'h04, d); chk("rx_empty_rd", d, 32'd0);
    rx_frame(8'($urandom), 1'b0);
    tick(2);
    rd(5'h08, d); chk("ferr_set", 32'(d[4]), 32'd1);
    rd(5'h0C, d); chk("ferr_nobyte", 32'(d[7:0]), 32'd0);
    wr(5'h08, 32'h10);
    rd(5'h08, d); chk("ferr_clr", 32'(d[4]), 32'd0);
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    rd(5'h08, d); chk("glitch_flags", 32'(d[5:3]), 32'd0);
    rd(5'h0C, d); chk("glitch_nobyte", 32'(d[7:0]), 32'd0);
    m_ovr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1);
      if (rxm.size() == DEPTH) m_ovr = 1'b1;
      else rxm.push_back(b);
      if ($urandom_range(3) == 0) begin
        rd(5'h04, d);
        chk("rx_rand_mid", d, {24'd0, rxm.pop_front()});
      end
    end
    rd(5'h0C, d); chk("rx_rand_count", 32'(d[7:0]), 32'(rxm.size()));
    rd(5'h08, d); chk("rx_rand_ovr", 32'(d[3]), 32'(m_ovr));
    chk("rx_rand_irq", 32'(uart_irq), 32'(rxm.size() != 0));
    while (rxm.size() > 0) begin
      rd(5'h04, d);
      chk("rx_rand_drain", d, {24'd0, rxm.pop_front()});
    end
    rd(5'h04, d); chk("rx_drained", d, 32'd0);
    wr(5'h08, 32'h08);
    rd(5'h08, d); chk("ovr_clr", 32'(d[5:3]), 32'd0);
    mon_en = 1'b0;
    wr(5'h10, 32'd2);
    rd(5'h10, d); chk("baud_min", d, 32'd4);
    wr(5'h14, 32'd2);
    for (int i = 0; i < DEPTH + 2; i++) wr(5'h00, $urandom);
    tick(3);
    chk("err_irq", 32'(uart_irq), 32'd1);
    reset = 1'b1;
    rw_address = 5'h08;
    read_request = 1'b1;
    tick(1);
    read_request = 1'b0;
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    chk("mid_rst_irq", 32'(uart_irq), 32'd0);
    chk("mid_rst_rresp", 32'(read_response), 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    chk("mid_rst_wresp", 32'(write_response), 32'd0);
    reset = 1'b0;
    tick(1);
    rd(5'h10, d); chk("post_rst_baud", d, 32'd10);
    rd(5'h08, d); chk("post_rst_status", d, 32'h05);
    rd(5'h0C, d); chk("post_rst_count", d, 32'd0);
    rd(5'h14, d); chk("post_rst_ctrl", d, 32'd0);
    tick(50);
    chk("post_rst_quiet", 32'(uart_tx), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
